// File: rtl/vga_timing_boxes.sv
// rtl/vga_timing_boxes.sv - parametrised VGA timing generator with slanted box overlays
// Optional edge border: define VGA_BORDER_EN.
module vga_timing_boxes #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 64,
    parameter int H_BP     = 120,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 16,
    parameter int HS_NEG   = 1,
    parameter int VS_NEG   = 1,
    parameter int CW       = 12,
    parameter int FRAC     = 4,
    parameter int NBOX     = 2,
    parameter int RGB_W    = 6
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_box,
    input  logic [2:0]           cfg_field,
    input  logic [CW+FRAC-1:0]   cfg_data,
    input  logic [RGB_W-1:0]     bg_rgb,
    output logic [CW-1:0]        x,
    output logic [CW-1:0]        y,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_de,
    output logic [RGB_W-1:0]     vga_rgb,
    output logic                 frame_start,
    output logic [15:0]          frame_count
);
    localparam int EW      = CW + FRAC;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_POL     = (HS_NEG != 0);
    localparam logic          VS_POL     = (VS_NEG != 0);

    localparam logic [2:0] F_YSTART = 3'd0;
    localparam logic [2:0] F_YEND   = 3'd1;
    localparam logic [2:0] F_X0     = 3'd2;
    localparam logic [2:0] F_X1     = 3'd3;
    localparam logic [2:0] F_DX0    = 3'd4;
    localparam logic [2:0] F_DX1    = 3'd5;
    localparam logic [2:0] F_COLOR  = 3'd6;
    localparam logic [2:0] F_ENABLE = 3'd7;

    logic [CW-1:0]    x_q, x_d, y_q, y_d;
    logic [15:0]      fc_q, fc_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             line_end, frame_end;
    logic [RGB_W-1:0] pix;

    logic [CW-1:0]    sh_ys_q  [NBOX];
    logic [CW-1:0]    sh_ye_q  [NBOX];
    logic [EW-1:0]    sh_x0_q  [NBOX];
    logic [EW-1:0]    sh_x1_q  [NBOX];
    logic [EW-1:0]    sh_dx0_q [NBOX];
    logic [EW-1:0]    sh_dx1_q [NBOX];
    logic [RGB_W-1:0] sh_col_q [NBOX];
    logic [NBOX-1:0]  sh_en_q;

    logic [CW-1:0]    lv_ys_q  [NBOX];
    logic [CW-1:0]    lv_ye_q  [NBOX];
    logic [EW-1:0]    lv_x0_q  [NBOX];
    logic [EW-1:0]    lv_x1_q  [NBOX];
    logic [EW-1:0]    lv_dx0_q [NBOX];
    logic [EW-1:0]    lv_dx1_q [NBOX];
    logic [RGB_W-1:0] lv_col_q [NBOX];
    logic [NBOX-1:0]  lv_en_q;

    logic [EW-1:0]    e0_q [NBOX];
    logic [EW-1:0]    e1_q [NBOX];
    logic [EW-1:0]    e0_d [NBOX];
    logic [EW-1:0]    e1_d [NBOX];

    always_comb begin
        line_end  = (x_q == H_LAST);
        frame_end = line_end && (y_q == V_LAST);
        x_d  = line_end ? '0 : x_q + CW'(1);
        y_d  = y_q;
        if (line_end) begin
            y_d = frame_end ? '0 : y_q + CW'(1);
        end
        fc_d = frame_end ? fc_q + 16'd1 : fc_q;
    end

    // Edges computed at the end of line y are the ones drawn on line y+1.
    always_comb begin
        for (int i = 0; i < NBOX; i++) begin
            e0_d[i] = e0_q[i];
            e1_d[i] = e1_q[i];
            if (!lv_en_q[i]) begin
                e0_d[i] = '0;
                e1_d[i] = '0;
            end else if (line_end) begin
                if (y_q == lv_ys_q[i]) begin
                    e0_d[i] = lv_x0_q[i];
                    e1_d[i] = lv_x1_q[i];
                end else if (y_q > lv_ys_q[i] && y_q < lv_ye_q[i]) begin
                    e0_d[i] = e0_q[i] + lv_dx0_q[i];
                    e1_d[i] = e1_q[i] + lv_dx1_q[i];
                end else begin
                    e0_d[i] = '0;
                    e1_d[i] = '0;
                end
            end
        end
    end

    // Hit is also gated by the line window, so line y_end itself never draws.
    always_comb begin
        de_d = (x_q < H_ACT) && (y_q < V_ACT);
        hs_d = HS_POL ^ ((x_q >= HS_BEG) && (x_q < HS_END));
        vs_d = VS_POL ^ ((y_q >= VS_BEG) && (y_q < VS_END));
        pix  = bg_rgb;
`ifdef VGA_BORDER_EN
        if (x_q == '0 || x_q == CW'(H_ACTIVE - 1) || y_q == '0 || y_q == CW'(V_ACTIVE - 1)) begin
            pix = {RGB_W{1'b1}} >> (RGB_W / 3);
        end
`endif
        for (int i = 0; i < NBOX; i++) begin
            if (lv_en_q[i] && y_q > lv_ys_q[i] && y_q < lv_ye_q[i] &&
                x_q >= e0_q[i][EW-1:FRAC] && x_q < e1_q[i][EW-1:FRAC]) begin
                pix = lv_col_q[i];
            end
        end
        rgb_d = de_d ? pix : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            hs_q    <= HS_POL;
            vs_q    <= VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            sh_en_q <= '0;
            lv_en_q <= '0;
            for (int i = 0; i < NBOX; i++) begin
                sh_ys_q[i]  <= '0;
                sh_ye_q[i]  <= '0;
                sh_x0_q[i]  <= '0;
                sh_x1_q[i]  <= '0;
                sh_dx0_q[i] <= '0;
                sh_dx1_q[i] <= '0;
                sh_col_q[i] <= '0;
                lv_ys_q[i]  <= '0;
                lv_ye_q[i]  <= '0;
                lv_x0_q[i]  <= '0;
                lv_x1_q[i]  <= '0;
                lv_dx0_q[i] <= '0;
                lv_dx1_q[i] <= '0;
                lv_col_q[i] <= '0;
                e0_q[i]     <= '0;
                e1_q[i]     <= '0;
            end
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            rgb_q <= rgb_d;
            if (frame_end) begin
                lv_en_q <= sh_en_q;
            end
            for (int i = 0; i < NBOX; i++) begin
                e0_q[i] <= e0_d[i];
                e1_q[i] <= e1_d[i];
                if (frame_end) begin
                    lv_ys_q[i]  <= sh_ys_q[i];
                    lv_ye_q[i]  <= sh_ye_q[i];
                    lv_x0_q[i]  <= sh_x0_q[i];
                    lv_x1_q[i]  <= sh_x1_q[i];
                    lv_dx0_q[i] <= sh_dx0_q[i];
                    lv_dx1_q[i] <= sh_dx1_q[i];
                    lv_col_q[i] <= sh_col_q[i];
                end
                if (cfg_we && cfg_box == 3'(i)) begin
                    case (cfg_field)
                        F_YSTART: sh_ys_q[i]  <= cfg_data[CW-1:0];
                        F_YEND:   sh_ye_q[i]  <= cfg_data[CW-1:0];
                        F_X0:     sh_x0_q[i]  <= cfg_data;
                        F_X1:     sh_x1_q[i]  <= cfg_data;
                        F_DX0:    sh_dx0_q[i] <= cfg_data;
                        F_DX1:    sh_dx1_q[i] <= cfg_data;
                        F_COLOR:  sh_col_q[i] <= cfg_data[RGB_W-1:0];
                        F_ENABLE: sh_en_q[i]  <= cfg_data[0];
                        default:  sh_en_q[i]  <= sh_en_q[i];
                    endcase
                end
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_rgb     = rgb_q;
    assign frame_count = fc_q;
    assign frame_start = (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_boxes.sv
// tb/tb_vga_timing_boxes.sv - randomized self-checking bench for vga_timing_boxes
module tb_vga_timing_boxes;
    localparam int HA = 64, HF = 4, HSW = 8, HB = 8, HT = HA + HF + HSW + HB;
    localparam int VA = 40, VF = 1, VSW = 3, VB = 2, VT = VA + VF + VSW + VB;
    localparam int CW = 12, FRAC = 4, NB = 2, RW = 6;

    logic          vga_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_box = '0;
    logic [2:0]    cfg_field = '0;
    logic [15:0]   cfg_data = '0;
    logic [5:0]    bg_rgb = '0;
    logic [11:0]   x, y;
    logic          vga_hs, vga_vs, vga_de, frame_start;
    logic [5:0]    vga_rgb;
    logic [15:0]   frame_count;

    vga_timing_boxes #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_NEG(1), .VS_NEG(1), .CW(CW), .FRAC(FRAC), .NBOX(NB), .RGB_W(RW)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_box(cfg_box),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .bg_rgb(bg_rgb),
        .x(x), .y(y), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    int          mx, my, mframe;
    logic [11:0] sh_ys [NB], sh_ye [NB], lv_ys [NB], lv_ye [NB];
    logic [15:0] sh_x0 [NB], sh_x1 [NB], sh_dx0 [NB], sh_dx1 [NB];
    logic [15:0] lv_x0 [NB], lv_x1 [NB], lv_dx0 [NB], lv_dx1 [NB];
    logic [5:0]  sh_col [NB], lv_col [NB];
    logic        sh_en [NB], lv_en [NB];
    logic        e_hs, e_vs, e_de;
    logic [5:0]  e_rgb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at x=%0d y=%0d frame=%0d: got %0h want %0h", tag, mx, my, mframe, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mframe = 0;
        for (int i = 0; i < NB; i++) begin
            sh_ys[i] = '0; sh_ye[i] = '0; sh_x0[i] = '0; sh_x1[i] = '0;
            sh_dx0[i] = '0; sh_dx1[i] = '0; sh_col[i] = '0; sh_en[i] = 1'b0;
            lv_ys[i] = '0; lv_ye[i] = '0; lv_x0[i] = '0; lv_x1[i] = '0;
            lv_dx0[i] = '0; lv_dx1[i] = '0; lv_col[i] = '0; lv_en[i] = 1'b0;
        end
    endtask

    // Closed-form edges: line L of a window uses init + (L - y_start - 1) * dx.
    function automatic logic [5:0] exp_pixel(input int px, input int py, input logic [5:0] bg);
        logic [5:0]  p;
        logic [15:0] e0, e1;
        int          k;
        if (px >= HA || py >= VA) return 6'd0;
        p = bg;
`ifdef VGA_BORDER_EN
        if (px == 0 || px == HA - 1 || py == 0 || py == VA - 1) p = 6'h0F;
`endif
        for (int i = 0; i < NB; i++) begin
            if (lv_en[i] && int'(lv_ys[i]) < py && py < int'(lv_ye[i])) begin
                k  = py - int'(lv_ys[i]) - 1;
                e0 = 16'(int'(lv_x0[i]) + k * int'($signed(lv_dx0[i])));
                e1 = 16'(int'(lv_x1[i]) + k * int'($signed(lv_dx1[i])));
                if (int'(e0[15:4]) <= px && px < int'(e1[15:4])) p = lv_col[i];
            end
        end
        return p;
    endfunction

    task automatic step();
        int b;
        e_hs  = !(mx >= HA + HF && mx < HA + HF + HSW);
        e_vs  = !(my >= VA + VF && my < VA + VF + VSW);
        e_de  = (mx < HA && my < VA);
        e_rgb = exp_pixel(mx, my, bg_rgb);
        if (mx == HT - 1 && my == VT - 1) begin
            for (int i = 0; i < NB; i++) begin
                lv_ys[i] = sh_ys[i]; lv_ye[i] = sh_ye[i]; lv_x0[i] = sh_x0[i];
                lv_x1[i] = sh_x1[i]; lv_dx0[i] = sh_dx0[i]; lv_dx1[i] = sh_dx1[i];
                lv_col[i] = sh_col[i]; lv_en[i] = sh_en[i];
            end
        end
        b = int'(cfg_box);
        if (cfg_we && b < NB) begin
            case (cfg_field)
                3'd0: sh_ys[b]  = cfg_data[11:0];
                3'd1: sh_ye[b]  = cfg_data[11:0];
                3'd2: sh_x0[b]  = cfg_data;
                3'd3: sh_x1[b]  = cfg_data;
                3'd4: sh_dx0[b] = cfg_data;
                3'd5: sh_dx1[b] = cfg_data;
                3'd6: sh_col[b] = cfg_data[5:0];
                default: sh_en[b] = cfg_data[0];
            endcase
        end
        mx++;
        if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) begin
                my = 0;
                mframe = (mframe + 1) % 65536;
            end
        end
        @(posedge vga_clk);
        #1;
        check_eq("x", x, mx);
        check_eq("y", y, my);
        check_eq("hs", vga_hs, e_hs);
        check_eq("vs", vga_vs, e_vs);
        check_eq("de", vga_de, e_de);
        check_eq("rgb", vga_rgb, e_rgb);
        check_eq("frame_start", frame_start, (mx == 0 && my == 0));
        check_eq("frame_count", frame_count, mframe);
        cfg_we = 1'b0;
        bg_rgb = 6'($urandom);
    endtask

    task automatic cfg_write(input int b, input int f, input int d);
        cfg_we    = 1'b1;
        cfg_box   = 3'(b);
        cfg_field = 3'(f);
        cfg_data  = 16'(d);
        step();
    endtask

    task automatic seek(input int tx, input int ty);
        int n = 0;
        while (!(mx == tx && my == ty) && n < HT * VT + 2) begin
            step();
            n++;
        end
        check_eq("seek", (mx == tx && my == ty), 1);
    endtask

    task automatic rand_cycles(input int n);
        int f, d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                f = $urandom_range(0, 7);
                case (f)
                    0, 1:    d = $urandom_range(0, VT + 2);
                    2, 3:    d = $urandom_range(0, HT * 16);
                    4, 5:    d = $urandom_range(0, 80) - 40;
                    6:       d = $urandom;
                    default: d = ($urandom_range(0, 3) != 0);
                endcase
                cfg_we    = 1'b1;
                cfg_box   = 3'($urandom_range(0, 3));
                cfg_field = 3'(f);
                cfg_data  = 16'(d);
            end
            step();
        end
    endtask

    task automatic reset_mid(input int tx, input int ty);
        seek(tx, ty);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_hs", vga_hs, 1);
        check_eq("rst_vs", vga_vs, 1);
        check_eq("rst_de", vga_de, 0);
        check_eq("rst_rgb", vga_rgb, 0);
        check_eq("rst_x", x, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_fc", frame_count, 0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #2;
        cfg_we = 1'b0;
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge vga_clk);
        #3;
        check_eq("init_x", x, 0);
        check_eq("init_y", y, 0);
        check_eq("init_hs", vga_hs, 1);
        check_eq("init_vs", vga_vs, 1);
        check_eq("init_de", vga_de, 0);
        check_eq("init_rgb", vga_rgb, 0);
        check_eq("init_fc", frame_count, 0);
        check_eq("init_fs", frame_start, 1);
        bg_rgb  = 6'h2A;
        reset_n = 1'b1;

        cfg_write(0, 0, 5);  cfg_write(0, 1, 12); cfg_write(0, 2, 423); cfg_write(0, 3, 603);
        cfg_write(0, 4, 14); cfg_write(0, 5, 11); cfg_write(0, 6, 'h30); cfg_write(0, 7, 1);
        cfg_write(1, 0, 3);  cfg_write(1, 1, 15); cfg_write(1, 2, 480); cfg_write(1, 3, 640);
        cfg_write(1, 4, 0);  cfg_write(1, 5, 0);  cfg_write(1, 6, 'h0C); cfg_write(1, 7, 1);
        cfg_write(2, 7, 1);  cfg_write(5, 6, 'h3F);
        seek(HT - 1, VT - 1); step();

        seek(HT - 1, VT - 1); cfg_write(0, 2, 80);
        seek(HT - 1, VT - 1); step();

        cfg_write(0, 2, 600); cfg_write(0, 4, -10);
        cfg_write(1, 2, 16);  cfg_write(1, 4, -40); cfg_write(1, 3, 800);
        seek(HT - 1, VT - 1); step();
        seek(HT - 1, VT - 1); step();

        rand_cycles(6 * HT * VT);

        reset_mid(HA + HF + 3, VA + VF + 1);
        cfg_write(0, 0, 2); cfg_write(0, 1, 30); cfg_write(0, 3, 1000); cfg_write(0, 7, 1);
        seek(HT - 1, VT - 1); step();
        reset_mid(10, 10);
        rand_cycles(HT * VT / 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
